alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Issue stage that sits directly upstream of the combinational 4-bit ALU and also captures its result. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU operand and control inputs from the FIFO head, then registers the ALU's 5-bit output, with flags, into a result slot that has its own valid/ready handshake. All ALU traffic is serialised through this block, and request order is preserved.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, ≥2)
CNT_W, 8, width of the saturating completed-operation counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_op  in  2  0=ADD, 1=AND, 2=XOR, 3=ALL_ONES
in_a  in  4  operand 1
in_b  in  4  operand 2
alu_in_1  out  4  to ALU in_1 (FIFO head operand a)
alu_in_2  out  4  to ALU in_2 (FIFO head operand b)
alu_control  out  2  to ALU control (FIFO head op)
alu_out  in  5  from ALU out (combinational from the three above)
res_valid  out  1  result slot full
res_ready  in  1  consumer takes result when res_valid && res_ready
res_data  out  5  captured alu_out
res_op  out  2  op that produced res_data
res_zero  out  1  res_data == 5'b0 (all 5 bits)
res_carry  out  1  res_op==ADD && res_data[4]
busy  out  1  FIFO non-empty || res_valid
op_count  out  CNT_W  results delivered (handshake completions), saturates at all-ones

Behaviour:
- Reset (sync, rst high at a rising edge) clears:
  - FIFO pointers and count to 0;
  - res_valid, res_data, res_op, res_zero, res_carry, op_count to 0.
  - Reset has priority over every other event.
  - In-flight FIFO entries and an unconsumed result are discarded; no partial handshake survives.
- in_ready = (fifo_count < DEPTH). It is registered-state based and combinationally independent of res_ready. A full FIFO never accepts a request, even if a pop happens in the same cycle.
- FIFO push on in_valid && in_ready. Pointers wrap modulo DEPTH.
- alu_in_1/alu_in_2/alu_control = FIFO head fields whenever non-empty. When empty, they drive 0.
- Load condition: load = fifo_nonempty && (!res_valid || res_ready). On load, in the same edge:
  - pop the head;
  - res_data <= alu_out; res_op <= head op; res_zero and res_carry are computed from alu_out and head op;
  - res_valid <= 1.
- If res_valid && res_ready && !load, then res_valid <= 0. The data fields hold their last values.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both operations occur.
- Push into an empty FIFO: the entry becomes the head after that edge. It can load on the next edge.
- Latency: request accepted at edge k gives res_valid high after edge k+1, provided the slot is free or being drained. Sustained throughput is 1 op/cycle with res_ready held high.
- op_count increments on each res_valid && res_ready and holds at 2^CNT_W−1.
- Total buffering is DEPTH+1 outstanding ops (FIFO plus result slot).
- The block does not check alu_out against the op. It is captured as presented. For op 3 the ALU returns 5'b11111.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings ALU_ADD=2'd0, ALU_AND=2'd1, ALU_XOR=2'd2, ALU_ONES=2'd3;
  - a request struct {op[1:0], a[3:0], b[3:0]};
  - the result width constant 5.
- One sub-module is natural: sync_fifo (parameterised width/depth, push/pop/full/empty/count), used for the request buffer.
- The result slot and counter stay in the top.

Test Plan:
- Reset, then one request ADD a=4'hF b=4'h1 with res_ready=1 -> res_valid after 2 edges, res_data=5'h10, res_carry=1, res_zero=0, op_count=1.
- AND a=4'hA b=4'h5 -> res_data=5'h00, res_zero=1, res_carry=0. Then XOR a=4'hC b=4'hA -> res_data=5'h06. Then op 3 -> res_data=5'h1F, res_carry=0.
- Backpressure: res_ready=0, present 6 back-to-back requests (DEPTH=4) -> exactly 5 accepted. in_ready low from the 6th cycle. Raise res_ready -> 5 results in issue order on 5 consecutive cycles; in_ready reasserts after the first drain.
- Streaming: 16 requests with in_valid and res_ready held high -> one result per cycle after initial latency. The FIFO never exceeds 1 entry. op_count=16.
- Reset mid-operation: FIFO holding 3 entries and res_valid=1, assert rst one cycle -> next cycle res_valid=0, in_ready=1, busy=0, op_count=0. No stale result appears afterwards.
- Counter saturation with CNT_W=2: deliver 5 results -> op_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: op encodings, request layout and
// the result-flag helper used when the result slot is loaded.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_AND  = 2'd1,
    ALU_XOR  = 2'd2,
    ALU_ONES = 2'd3
  } alu_op_e;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;

  typedef struct packed {
    alu_op_e           op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_req_t;

  localparam int REQ_W = $bits(alu_req_t);

  // Carry only has meaning for an addition; other ops never report it.
  function automatic logic carry_flag(input alu_op_e op, input logic [RES_W-1:0] res);
    return (op == ALU_ADD) && res[RES_W-1];
  endfunction

  function automatic logic zero_flag(input logic [RES_W-1:0] res);
    return (res == '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a push into a full FIFO and a pop
// from an empty FIFO are ignored, whatever else happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    rdata    = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the combinational ALU: buffers requests, presents the oldest
// one to the ALU and captures the ALU output plus flags into a result slot.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [3:0]        in_a,
  input  logic [3:0]        in_b,
  output logic [3:0]        alu_in_1,
  output logic [3:0]        alu_in_2,
  output logic [1:0]        alu_control,
  input  logic [4:0]        alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4:0]        res_data,
  output logic [1:0]        res_op,
  output logic              res_zero,
  output logic              res_carry,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int AW = $clog2(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready never depends combinationally on the same port's valid.
  alu_req_t          push_req, head_req;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;
  logic              push, load, deliver;

  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  alu_op_e           res_op_q, res_op_d;
  logic              res_zero_q, res_zero_d;
  logic              res_carry_q, res_carry_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  assign push_req = '{op: alu_op_e'(in_op), a: in_a, b: in_b};

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_req),
    .pop   (load),
    .rdata (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    in_ready = !fifo_full;
    push     = in_valid && !fifo_full;
    deliver  = res_valid_q && res_ready;
    load     = !fifo_empty && (!res_valid_q || res_ready);

    alu_in_1    = fifo_empty ? 4'd0 : head_req.a;
    alu_in_2    = fifo_empty ? 4'd0 : head_req.b;
    alu_control = fifo_empty ? 2'd0 : head_req.op;

    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
    // A load refills the slot in the same edge it drains, keeping 1 op/cycle.
    if (load) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_op_d    = head_req.op;
      res_zero_d  = zero_flag(alu_out);
      res_carry_d = carry_flag(head_req.op, alu_out);
    end else if (deliver) begin
      res_valid_d = 1'b0;
    end

    op_count_d = op_count_q;
    if (deliver && (op_count_q != '1)) op_count_d = op_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= ALU_ADD;
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    res_valid = res_valid_q;
    res_data  = res_data_q;
    res_op    = res_op_q;
    res_zero  = res_zero_q;
    res_carry = res_carry_q;
    op_count  = op_count_q;
    busy      = (fifo_count != '0) || res_valid_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, queue-based reference model and
// directed/random phases; a second instance exercises a 2-bit counter.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic       rst, in_valid, in_ready, res_valid, res_ready;
  logic [1:0] in_op, alu_control, res_op;
  logic [3:0] in_a, in_b, alu_in_1, alu_in_2;
  logic [4:0] alu_out, res_data;
  logic       res_zero, res_carry, busy;
  logic [7:0] op_count;

  // Saturation instance
  logic       rst2, in_valid2, in_ready2, res_valid2, res_ready2;
  logic [1:0] in_op2, alu_control2, res_op2;
  logic [3:0] in_a2, in_b2, alu_in_12, alu_in_22;
  logic [4:0] alu_out2, res_data2;
  logic       res_zero2, res_carry2, busy2;
  logic [1:0] op_count2;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [4:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a & b};
      2'd2:    return {1'b0, a ^ b};
      default: return 5'h1F;
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_control, alu_in_1, alu_in_2);
  assign alu_out2 = alu_ref(alu_control2, alu_in_12, alu_in_22);

  alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_control(alu_control),
    .alu_out(alu_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_zero(res_zero),
    .res_carry(res_carry), .busy(busy), .op_count(op_count)
  );

  alu_op_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op2), .in_a(in_a2), .in_b(in_b2),
    .alu_in_1(alu_in_12), .alu_in_2(alu_in_22), .alu_control(alu_control2),
    .alu_out(alu_out2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_data(res_data2), .res_op(res_op2), .res_zero(res_zero2),
    .res_carry(res_carry2), .busy(busy2), .op_count(op_count2)
  );

  // Reference model: accepted-but-unissued requests {op,a,b} plus the slot.
  logic [9:0] exp_q[$];
  logic       m_valid, m_zero, m_carry;
  logic [4:0] m_data;
  logic [1:0] m_op;
  logic [7:0] m_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_valid = 1'b0; m_zero = 1'b0; m_carry = 1'b0;
    m_data  = 5'h0; m_op = 2'd0; m_cnt = 8'h0;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic rr);
    in_valid = v; in_op = op; in_a = a; in_b = b; res_ready = rr;
  endtask

  task automatic drive_rand(input logic v, input logic rr);
    drive(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rr);
  endtask

  // Called at a negedge with inputs set: check outputs, advance model, clock.
  task automatic cycle();
    logic       exp_ready, push, load, deliver;
    logic [9:0] h;
    exp_ready = (exp_q.size() < DEPTH);
    h = (exp_q.size() != 0) ? exp_q[0] : 10'h0;
    check("in_ready",  {7'h0, in_ready},  {7'h0, exp_ready});
    check("res_valid", {7'h0, res_valid}, {7'h0, m_valid});
    check("busy",      {7'h0, busy},      {7'h0, (exp_q.size() != 0) || m_valid});
    check("op_count",  op_count, m_cnt);
    check("res_data",  {3'h0, res_data},  {3'h0, m_data});
    check("res_op",    {6'h0, res_op},    {6'h0, m_op});
    check("res_zero",  {7'h0, res_zero},  {7'h0, m_zero});
    check("res_carry", {7'h0, res_carry}, {7'h0, m_carry});
    check("alu_ctl",   {6'h0, alu_control}, {6'h0, h[9:8]});
    check("alu_in_1",  {4'h0, alu_in_1},  {4'h0, h[7:4]});
    check("alu_in_2",  {4'h0, alu_in_2},  {4'h0, h[3:0]});

    push    = in_valid && exp_ready;
    load    = (exp_q.size() != 0) && (!m_valid || res_ready);
    deliver = m_valid && res_ready;
    if (deliver && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    if (load) begin
      h       = exp_q.pop_front();
      m_data  = alu_ref(h[9:8], h[7:4], h[3:0]);
      m_op    = h[9:8];
      m_zero  = (m_data == 5'h0);
      m_carry = (h[9:8] == 2'd0) && m_data[4];
      m_valid = 1'b1;
    end else if (deliver) begin
      m_valid = 1'b0;
    end
    if (push) exp_q.push_back({in_op, in_a, in_b});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue_one(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    drive(1'b1, op, a, b, 1'b1);
    cycle();
    drive(1'b0, op, a, b, 1'b1);
    cycle();
  endtask

  initial begin
    drive(1'b0, 2'd0, 4'd0, 4'd0, 1'b0);
    rst2 = 1'b1; in_valid2 = 1'b0; in_op2 = 2'd0; in_a2 = 4'd0; in_b2 = 4'd0; res_ready2 = 1'b0;
    do_reset();

    // Reset state and directed single operations
    cycle();
    issue_one(2'd0, 4'hF, 4'h1);
    check("add_valid", {7'h0, res_valid}, 8'h01);
    check("add_data",  {3'h0, res_data},  8'h10);
    check("add_carry", {7'h0, res_carry}, 8'h01);
    check("add_zero",  {7'h0, res_zero},  8'h00);
    cycle();
    check("add_count", op_count, 8'h01);

    issue_one(2'd1, 4'hA, 4'h5);
    check("and_data",  {3'h0, res_data},  8'h00);
    check("and_zero",  {7'h0, res_zero},  8'h01);
    check("and_carry", {7'h0, res_carry}, 8'h00);
    cycle();
    issue_one(2'd2, 4'hC, 4'hA);
    check("xor_data",  {3'h0, res_data},  8'h06);
    cycle();
    issue_one(2'd3, 4'h3, 4'h9);
    check("ones_data",  {3'h0, res_data},  8'h1F);
    check("ones_carry", {7'h0, res_carry}, 8'h00);
    cycle();

    // Backpressure: slot held, six back-to-back requests
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1, 1'b0);
      cycle();
    end
    drive_rand(1'b1, 1'b0);
    check("bp_full_ready", {7'h0, in_ready}, 8'h00);
    cycle();
    for (int i = 0; i < 7; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle();
    end
    check("bp_count", op_count, 8'h09);

    // Streaming: 16 requests with the consumer always ready
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1, 1'b1);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle();
    end
    check("stream_count", op_count, 8'd25);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      cycle();
    end

    // Reset with three queued entries and a full slot
    do_reset();
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b1, 1'b0);
      cycle();
    end
    check("pre_rst_busy",  {7'h0, busy},      8'h01);
    check("pre_rst_valid", {7'h0, res_valid}, 8'h01);
    do_reset();
    check("rst_valid",  {7'h0, res_valid}, 8'h00);
    check("rst_ready",  {7'h0, in_ready},  8'h01);
    check("rst_busy",   {7'h0, busy},      8'h00);
    check("rst_count",  op_count,          8'h00);
    for (int i = 0; i < 4; i++) begin
      drive_rand(1'b0, 1'b1);
      cycle();
    end

    // Counter saturation on the 2-bit instance
    rst2 = 1'b0; res_ready2 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      in_valid2 = (c <= 5);
      in_op2 = 2'($urandom_range(0, 3));
      in_a2  = 4'($urandom_range(0, 15));
      in_b2  = 4'($urandom_range(0, 15));
      @(posedge clk);
      @(negedge clk);
      check("sat_count", {6'h0, op_count2}, (c <= 2) ? 8'd0 : ((c - 2 > 3) ? 8'd3 : 8'(c - 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
